hwpf_issue_filter: RTL and testbench
====================================

Name: hwpf_issue_filter

Overview:
Downstream stage of the next-line prefetcher. It takes prefetch line addresses from the prefetcher's request port and drops duplicates of recently issued or still-queued lines. Surviving requests are buffered in a small FIFO and issued to the HPDcache prefetch arbiter port under a programmable minimum inter-issue gap. The block protects the dcache from redundant and bursty prefetch traffic.

Parameters:
ADDR_W, 40, physical address width in bits (matches addr_t)
LINE_BYTES, 64, cache line size in bytes; power of two
QUEUE_DEPTH, 4, issue FIFO entries; power of two, >=2
FILTER_DEPTH, 8, recent-line filter entries; >=1
MIN_GAP, 0, idle cycles forced after each issue; 0 allows back-to-back issue

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  clear queue, filter and throttle state
lock_i  in  1  freeze; no accept, no issue
pf_req_valid_i  in  1  prefetch request valid
pf_req_ready_o  out  1  request accepted when valid&ready
pf_req_addr_i  in  ADDR_W  prefetch byte address
dc_req_valid_o  out  1  issue request valid
dc_req_ready_i  in  1  arbiter accepts
dc_req_addr_o  out  ADDR_W  line-aligned issue address
drop_full_cnt_o  out  16  requests dropped because queue full
drop_dup_cnt_o  out  16  requests dropped as duplicates

Behaviour:
- Reset: all outputs 0; queue empty; filter invalid; throttle counter 0.
- Line address = addr[ADDR_W-1:log2(LINE_BYTES)]. Issued address has its low log2(LINE_BYTES) bits zero.
- pf_req_ready_o = ~lock_i & ~flush_i (combinational). There is no backpressure on full; excess requests are dropped.
- On accept, evaluation order:
  (1) If the line matches any valid filter entry or any valid queue entry: drop, drop_dup +1.
  (2) Else if the queue is full and not popping this cycle: drop, drop_full +1.
  (3) Else enqueue at the tail and write the line into the filter at a round-robin pointer; the pointer wraps at FILTER_DEPTH and overwrites the oldest entry.
- Full queue with a simultaneous pop: the push is accepted.
- Latency: an entry enqueued in cycle t can assert dc_req_valid_o at t+1 at the earliest. There is no input-to-output bypass.
- dc_req_valid_o = queue not empty & ~lock_i & (throttle==0). dc_req_addr_o = head entry.
- Pop on dc_req_valid_o & dc_req_ready_i. Head and address stay stable while valid and not popped.
- Throttle: a pop loads MIN_GAP into the counter. The counter decrements each cycle while nonzero; it holds during lock.
- Queue pointers: log2(QUEUE_DEPTH)+1 bits, wrap-around; full/empty are decoded from the MSB.
- flush_i (one cycle): the next state has an empty queue, all filter entries invalid, filter pointer 0 and throttle 0. Flush has priority over push and pop in the same cycle; no request is counted. Stat counters are not cleared by flush.
- lock_i: valid and ready are low; all state holds.
- Counters saturate at 0xFFFF.
- Asynchronous reset mid-operation aborts everything immediately; outputs return to their reset values.

Optional Feature:
HWPF_FILTER_STATS_EN.
- Defined: drop_full_cnt_o and drop_dup_cnt_o are live saturating counters as above.
- Undefined: no counter flops; both outputs are tied to 16'h0. Drop behaviour is unchanged.

Test Plan:
- Defaults, dc_req_ready_i=1, push 0x10000040 then 0x10000078 -> single issue of addr 0x10000040; drop_dup=1.
- QUEUE_DEPTH=4, dc_req_ready_i=0, push 5 distinct lines 0x0, 0x40, 0x80, 0xC0, 0x100 -> 4 queued; drop_full=1. Then ready=1 -> issues 0x0, 0x40, 0x80, 0xC0 in order.
- MIN_GAP=2, 3 entries queued, ready=1 -> valid/pop at cycles t, t+3, t+6.
- FILTER_DEPTH=8, push and drain 9 distinct lines, then re-push the first -> accepted and issued (evicted entry). Re-pushing the 9th line instead -> dup drop.
- 2 entries queued, flush_i pulsed while pushing 0x2000 -> next cycle valid=0, no count change. Re-push an old line -> accepted.
- lock_i high for 5 cycles with 1 entry queued and MIN_GAP=3 counting at 2 -> no valid during lock. Counter resumes from 2 after unlock; the issue occurs 2 cycles later.

Source files
------------

// File: rtl/hwpf_issue_filter.sv
// Prefetch issue filter: drops recently seen lines, queues survivors, issues under a minimum gap.
// Define HWPF_FILTER_STATS_EN to build the saturating drop counters; otherwise they read as zero.
module hwpf_issue_filter #(
  parameter int ADDR_W       = 40,
  parameter int LINE_BYTES   = 64,
  parameter int QUEUE_DEPTH  = 4,
  parameter int FILTER_DEPTH = 8,
  parameter int MIN_GAP      = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              lock_i,
  input  logic              pf_req_valid_i,
  output logic              pf_req_ready_o,
  input  logic [ADDR_W-1:0] pf_req_addr_i,
  output logic              dc_req_valid_o,
  input  logic              dc_req_ready_i,
  output logic [ADDR_W-1:0] dc_req_addr_o,
  output logic [15:0]       drop_full_cnt_o,
  output logic [15:0]       drop_dup_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int QA_W   = $clog2(QUEUE_DEPTH);
  localparam int FP_W   = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  logic [LINE_W-1:0]       q_mem [QUEUE_DEPTH];
  logic [QA_W:0]           wr_ptr, rd_ptr, q_count;
  logic                    q_empty, q_full;
  logic [QUEUE_DEPTH-1:0]  q_live;
  logic [LINE_W-1:0]       f_line [FILTER_DEPTH];
  logic [FILTER_DEPTH-1:0] f_vld;
  logic [FP_W-1:0]         f_ptr;
  logic [GAP_W-1:0]        thr;
  logic [LINE_W-1:0]       req_line;
  logic                    accept, hit, pop, push;
  logic                    unused_offset;

  assign req_line      = pf_req_addr_i[ADDR_W-1:OFF_W];
  assign unused_offset = ^pf_req_addr_i[OFF_W-1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign q_count = wr_ptr - rd_ptr;
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[QA_W] != rd_ptr[QA_W]) &&
                   (wr_ptr[QA_W-1:0] == rd_ptr[QA_W-1:0]);

  assign pf_req_ready_o = ~lock_i & ~flush_i;
  assign accept         = pf_req_valid_i & pf_req_ready_o;
  assign dc_req_valid_o = ~q_empty & ~lock_i & (thr == '0);
  assign dc_req_addr_o  = {q_mem[rd_ptr[QA_W-1:0]], {OFF_W{1'b0}}};
  assign pop            = dc_req_valid_o & dc_req_ready_i & ~flush_i;
  assign push           = accept & ~hit & (~q_full | pop);

  always_comb begin
    q_live = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      q_live[i] = ({1'b0, QA_W'(i) - rd_ptr[QA_W-1:0]} < q_count);
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FILTER_DEPTH; i++)
      if (f_vld[i] && (f_line[i] == req_line)) hit = 1'b1;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (q_live[i] && (q_mem[i] == req_line)) hit = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr[QA_W-1:0]] <= req_line;
        wr_ptr <= wr_ptr + (QA_W+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (QA_W+1)'(1);
    end
  end

  // Round-robin fill: once wrapped, each new line evicts the oldest one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_vld <= '0;
      f_ptr <= '0;
      for (int i = 0; i < FILTER_DEPTH; i++) f_line[i] <= '0;
    end else if (flush_i) begin
      f_vld <= '0;
      f_ptr <= '0;
    end else if (push) begin
      f_line[f_ptr] <= req_line;
      f_vld[f_ptr]  <= 1'b1;
      f_ptr <= (f_ptr == FP_W'(FILTER_DEPTH - 1)) ? '0 : f_ptr + FP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      thr <= '0;
    end else if (flush_i) begin
      thr <= '0;
    end else if (!lock_i) begin
      if (pop)              thr <= GAP_W'(MIN_GAP);
      else if (thr != '0)   thr <= thr - GAP_W'(1);
    end
  end

`ifdef HWPF_FILTER_STATS_EN
  logic [15:0] drop_full_cnt, drop_dup_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_full_cnt <= '0;
      drop_dup_cnt  <= '0;
    end else begin
      if (accept && hit && (drop_dup_cnt != 16'hFFFF))
        drop_dup_cnt <= drop_dup_cnt + 16'd1;
      if (accept && !hit && q_full && !pop && (drop_full_cnt != 16'hFFFF))
        drop_full_cnt <= drop_full_cnt + 16'd1;
    end
  end

  assign drop_full_cnt_o = drop_full_cnt;
  assign drop_dup_cnt_o  = drop_dup_cnt;
`else
  assign drop_full_cnt_o = 16'h0;
  assign drop_dup_cnt_o  = 16'h0;
`endif

endmodule

// File: tb/tb_hwpf_issue_filter.sv
// Bench for hwpf_issue_filter: three instances (MIN_GAP 0/2/3) share stimulus and a queue-based reference model.
module tb_hwpf_issue_filter;

`ifdef HWPF_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int QD = 4;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, lock = 1'b0, pf_valid = 1'b0, dc_ready = 1'b0;
  logic [39:0] pf_addr = '0;
  logic [2:0] dv, pr;
  logic [2:0][39:0] da;
  logic [2:0][15:0] df, dd;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  hwpf_issue_filter #(.MIN_GAP(0)) u_gap0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .pf_req_valid_i(pf_valid), .pf_req_ready_o(pr[0]), .pf_req_addr_i(pf_addr),
    .dc_req_valid_o(dv[0]), .dc_req_ready_i(dc_ready), .dc_req_addr_o(da[0]),
    .drop_full_cnt_o(df[0]), .drop_dup_cnt_o(dd[0]));

  hwpf_issue_filter #(.MIN_GAP(2)) u_gap2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .pf_req_valid_i(pf_valid), .pf_req_ready_o(pr[1]), .pf_req_addr_i(pf_addr),
    .dc_req_valid_o(dv[1]), .dc_req_ready_i(dc_ready), .dc_req_addr_o(da[1]),
    .drop_full_cnt_o(df[1]), .drop_dup_cnt_o(dd[1]));

  hwpf_issue_filter #(.MIN_GAP(3)) u_gap3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .lock_i(lock),
    .pf_req_valid_i(pf_valid), .pf_req_ready_o(pr[2]), .pf_req_addr_i(pf_addr),
    .dc_req_valid_o(dv[2]), .dc_req_ready_i(dc_ready), .dc_req_addr_o(da[2]),
    .drop_full_cnt_o(df[2]), .drop_dup_cnt_o(dd[2]));

  // Reference model: ordered list of queued lines, list of most recent accepted lines, gap countdown.
  int gap_of [3] = '{0, 2, 3};
  logic [33:0] mq [3][QD];
  int mqn [3];
  logic [33:0] mf [3][FD];
  int mfn [3];
  int mthr [3];
  int mdf [3];
  int mdd [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mqn[k] = 0; mfn[k] = 0; mthr[k] = 0; mdf[k] = 0; mdd[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit m_pop, m_hit;
        logic [33:0] ln;
        ln = pf_addr[39:6];
        if (flush) begin
          mqn[k] = 0; mfn[k] = 0; mthr[k] = 0;
        end else if (!lock) begin
          m_pop = (mqn[k] > 0) && (mthr[k] == 0) && dc_ready;
          m_hit = 1'b0;
          for (int j = 0; j < mfn[k]; j++) if (mf[k][j] == ln) m_hit = 1'b1;
          for (int j = 0; j < mqn[k]; j++) if (mq[k][j] == ln) m_hit = 1'b1;
          if (m_pop) mthr[k] = gap_of[k];
          else if (mthr[k] > 0) mthr[k] = mthr[k] - 1;
          if (m_pop) begin
            for (int j = 0; j < QD - 1; j++) mq[k][j] = mq[k][j+1];
            mqn[k] = mqn[k] - 1;
          end
          if (pf_valid) begin
            if (m_hit) begin
              if (mdd[k] < 65535) mdd[k] = mdd[k] + 1;
            end else if (mqn[k] == QD) begin
              if (mdf[k] < 65535) mdf[k] = mdf[k] + 1;
            end else begin
              mq[k][mqn[k]] = ln;
              mqn[k] = mqn[k] + 1;
              for (int j = FD - 1; j > 0; j--) mf[k][j] = mf[k][j-1];
              mf[k][0] = ln;
              if (mfn[k] < FD) mfn[k] = mfn[k] + 1;
            end
          end
        end
      end
    end
  end

  logic [39:0] ia0 [$];
  int it0 [$];
  int it1 [$];
  int it2 [$];

  always @(negedge clk) begin
    if (rst_n && dc_ready) begin
      if (dv[0]) begin ia0.push_back(da[0]); it0.push_back(cyc_n); end
      if (dv[1]) it1.push_back(cyc_n);
      if (dv[2]) it2.push_back(cyc_n);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    ia0.delete(); it0.delete(); it1.delete(); it2.delete();
  endtask

  task automatic do_reset();
    flush = 0; lock = 0; pf_valid = 0; dc_ready = 0; pf_addr = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();
    clear_log();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({dv[k], da[k], df[k], dd[k]} !== '0)
        $display("FAIL reset_outputs inst=%0d got v=%0b a=%h df=%0d dd=%0d want all zero", k, dv[k], da[k], df[k], dd[k]);
      else n_pass++;
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_dup();
    do_reset();
    dc_ready = 1; pf_valid = 1; pf_addr = 40'h0010000040;
    step();
    pf_addr = 40'h0010000078;
    #1;
    n_checks++;
    if (dv[0] !== 1'b1 || da[0] !== 40'h0010000040)
      $display("FAIL dup_first_issue got v=%0b a=%h want v=1 a=0010000040", dv[0], da[0]);
    else n_pass++;
    step();
    pf_valid = 0;
    repeat (3) step();
    n_checks++;
    if (ia0.size() != 1 || ia0[0] !== 40'h0010000040)
      $display("FAIL dup_issue_count got n=%0d want n=1 a=0010000040", ia0.size());
    else n_pass++;
    n_checks++;
    if (dd[0] !== (STATS ? 16'd1 : 16'd0))
      $display("FAIL dup_counter got %0d want %0d", dd[0], STATS ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [39:0] exp [4];
    exp = '{40'h0, 40'h40, 40'h80, 40'hC0};
    do_reset();
    dc_ready = 0;
    for (int i = 0; i < 5; i++) begin
      pf_valid = 1; pf_addr = 40'(i * 64);
      step();
    end
    pf_valid = 0;
    #1;
    n_checks++;
    if (dv[0] !== 1'b1 || da[0] !== 40'h0)
      $display("FAIL full_head got v=%0b a=%h want v=1 a=0", dv[0], da[0]);
    else n_pass++;
    n_checks++;
    if (df[0] !== (STATS ? 16'd1 : 16'd0) || dd[0] !== 16'd0)
      $display("FAIL full_counter got df=%0d dd=%0d want df=%0d dd=0", df[0], dd[0], STATS ? 1 : 0);
    else n_pass++;
    dc_ready = 1;
    repeat (6) step();
    n_checks++;
    if (ia0.size() != 4)
      $display("FAIL full_drain_count got %0d want 4", ia0.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ia0[i] !== exp[i]) $display("FAIL full_order idx=%0d got %h want %h", i, ia0[i], exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_gap();
    int t0;
    do_reset();
    dc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      pf_valid = 1; pf_addr = 40'h1000 + 40'(i * 64);
      step();
    end
    pf_valid = 0;
    step();
    dc_ready = 1; t0 = cyc_n;
    repeat (12) step();
    n_checks++;
    if (it0.size() != 3 || it0[0] != t0 || it0[1] != t0 + 1 || it0[2] != t0 + 2)
      $display("FAIL gap0_back_to_back got n=%0d want issues at %0d,%0d,%0d", it0.size(), t0, t0 + 1, t0 + 2);
    else n_pass++;
    n_checks++;
    if (it1.size() != 3 || it1[0] != t0 || it1[1] != t0 + 3 || it1[2] != t0 + 6)
      $display("FAIL gap2_spacing got n=%0d want issues at %0d,%0d,%0d", it1.size(), t0, t0 + 3, t0 + 6);
    else n_pass++;
    n_checks++;
    if (it2.size() != 3 || it2[0] != t0 || it2[1] != t0 + 4 || it2[2] != t0 + 8)
      $display("FAIL gap3_spacing got n=%0d want issues at %0d,%0d,%0d", it2.size(), t0, t0 + 4, t0 + 8);
    else n_pass++;
  endtask

  task automatic test_filter_evict();
    do_reset();
    dc_ready = 1;
    for (int i = 0; i < 9; i++) begin
      pf_valid = 1; pf_addr = 40'h2000 + 40'(i * 64);
      step();
    end
    pf_valid = 0;
    repeat (3) step();
    n_checks++;
    if (ia0.size() != 9) $display("FAIL evict_fill got %0d issues want 9", ia0.size());
    else n_pass++;
    pf_valid = 1; pf_addr = 40'h2000;
    step();
    pf_valid = 0;
    repeat (3) step();
    n_checks++;
    if (ia0.size() != 10 || ia0[ia0.size()-1] !== 40'h2000)
      $display("FAIL evict_repush_first got n=%0d want n=10 last=2000", ia0.size());
    else n_pass++;
    pf_valid = 1; pf_addr = 40'h2200;
    step();
    pf_valid = 0;
    repeat (3) step();
    n_checks++;
    if (ia0.size() != 10) $display("FAIL evict_repush_ninth got %0d issues want 10", ia0.size());
    else n_pass++;
    n_checks++;
    if (dd[0] !== (STATS ? 16'd1 : 16'd0))
      $display("FAIL evict_dup_counter got %0d want %0d", dd[0], STATS ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    dc_ready = 0;
    pf_valid = 1; pf_addr = 40'h3000; step();
    pf_addr = 40'h3040; step();
    flush = 1; pf_addr = 40'h2000;
    #1;
    n_checks++;
    if (pr !== 3'b000) $display("FAIL flush_ready got %b want 000", pr);
    else n_pass++;
    step();
    flush = 0; pf_valid = 0;
    #1;
    n_checks++;
    if (dv !== 3'b000 || df[0] !== 16'd0 || dd[0] !== 16'd0)
      $display("FAIL flush_clears got v=%b df=%0d dd=%0d want v=000 df=0 dd=0", dv, df[0], dd[0]);
    else n_pass++;
    step();
    pf_valid = 1; pf_addr = 40'h3000;
    step();
    pf_valid = 0;
    #1;
    n_checks++;
    if (dv[0] !== 1'b1 || da[0] !== 40'h3000 || dd[0] !== 16'd0)
      $display("FAIL flush_repush got v=%0b a=%h dd=%0d want v=1 a=3000 dd=0", dv[0], da[0], dd[0]);
    else n_pass++;
    step();
  endtask

  task automatic test_lock();
    int c0, u;
    do_reset();
    dc_ready = 1;
    pf_valid = 1; pf_addr = 40'h4000; c0 = cyc_n; step();
    pf_addr = 40'h4040; step();
    pf_valid = 0; step();
    lock = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (dv !== 3'b000 || pr !== 3'b000)
        $display("FAIL lock_quiet cyc=%0d got v=%b r=%b want 000/000", i, dv, pr);
      else n_pass++;
      step();
    end
    lock = 0; u = cyc_n;
    repeat (6) step();
    n_checks++;
    if (it2.size() != 2 || it2[0] != c0 + 1)
      $display("FAIL lock_first_issue got n=%0d want n=2 first at %0d", it2.size(), c0 + 1);
    else n_pass++;
    n_checks++;
    if (it2.size() != 2 || it2[1] != u + 2)
      $display("FAIL lock_resume got n=%0d want second issue at %0d", it2.size(), u + 2);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    dc_ready = 0;
    pf_valid = 1; pf_addr = 40'h6000; step();
    pf_valid = 1; pf_addr = 40'h6000; step();
    pf_valid = 0;
    #1;
    n_checks++;
    if (dv[0] !== 1'b1) $display("FAIL areset_pre got v=%0b want 1", dv[0]);
    else n_pass++;
    #1 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({dv[k], da[k], df[k], dd[k]} !== '0)
        $display("FAIL areset_outputs inst=%0d got v=%0b a=%h df=%0d dd=%0d want all zero", k, dv[k], da[k], df[k], dd[k]);
      else n_pass++;
    end
    step();
    rst_n = 1;
    step();
    n_checks++;
    if (dv !== 3'b000) $display("FAIL areset_empty got v=%b want 000", dv);
    else n_pass++;
  endtask

  task automatic test_random();
    logic exp_v;
    logic [39:0] exp_a;
    logic [15:0] exp_df, exp_dd;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      flush = (r < 3);
      lock  = (r >= 3 && r < 11);
      pf_valid = ($urandom_range(0, 99) < 60);
      pf_addr  = 40'h0050000000 + 40'($urandom_range(0, 11)) * 40'd64 + 40'($urandom_range(0, 63));
      dc_ready = ($urandom_range(0, 99) < 70);
      #1;
      for (int k = 0; k < 3; k++) begin
        exp_v  = (mqn[k] > 0) && !lock && (mthr[k] == 0);
        exp_df = STATS ? 16'(mdf[k]) : 16'd0;
        exp_dd = STATS ? 16'(mdd[k]) : 16'd0;
        n_checks++;
        if (dv[k] !== exp_v) $display("FAIL rand_valid cyc=%0d inst=%0d got %0b want %0b", c, k, dv[k], exp_v);
        else n_pass++;
        n_checks++;
        if (pr[k] !== (!lock && !flush)) $display("FAIL rand_ready cyc=%0d inst=%0d got %0b want %0b", c, k, pr[k], !lock && !flush);
        else n_pass++;
        if (exp_v) begin
          exp_a = {mq[k][0], 6'b0};
          n_checks++;
          if (da[k] !== exp_a) $display("FAIL rand_addr cyc=%0d inst=%0d got %h want %h", c, k, da[k], exp_a);
          else n_pass++;
        end
        n_checks++;
        if (df[k] !== exp_df || dd[k] !== exp_dd)
          $display("FAIL rand_counters cyc=%0d inst=%0d got df=%0d dd=%0d want df=%0d dd=%0d", c, k, df[k], dd[k], exp_df, exp_dd);
        else n_pass++;
      end
      step();
    end
    flush = 0; lock = 0; pf_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached with %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dup();
    test_full();
    test_gap();
    test_filter_evict();
    test_flush();
    test_lock();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
